// File: rtl/tmr_evt_pkg.sv
// Shared types and helpers for the timer external-event generator.
// Event-mode codes mirror the timer's TMR_ETM_* encoding.
package tmr_evt_pkg;

    localparam logic [2:0] TMR_ETM_NONE = 3'd0;
    localparam logic [2:0] TMR_ETM_RISE = 3'd1;
    localparam logic [2:0] TMR_ETM_FALL = 3'd2;
    localparam logic [2:0] TMR_ETM_CLER = 3'd3;
    localparam logic [2:0] TMR_ETM_LOAD = 3'd4;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        EVT_IDLE     = 2'd0,
        EVT_ACTIVE   = 2'd1,
        EVT_INACTIVE = 2'd2,
        EVT_DONE     = 2'd3
    } evt_state_e;

    // Increment that sticks at the all-ones value of a 'width'-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val == max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/tmr_edge_det.sv
// Registered-previous-value edge detector; selectable rise, fall or both edges.
module tmr_edge_det
    import tmr_evt_pkg::*;
#(
    parameter int EDGE_SEL = EDGE_RISE
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    always_comb begin
        edge_o = 1'b0;
        if (EDGE_SEL == EDGE_FALL) begin
            edge_o = ~sig_i & prev_q;
        end else if (EDGE_SEL == EDGE_BOTH) begin
            edge_o = sig_i ^ prev_q;
        end else begin
            edge_o = sig_i & ~prev_q;
        end
    end

endmodule

// File: rtl/tmr_evt_gen.sv
// Event-pulse generator driving the timer capture input; counts events and irqs
// and measures the delay from each active-phase entry to the irq rise.
//
//   state        | meaning
//   EVT_IDLE     | waiting for start, capch at idle level
//   EVT_ACTIVE   | capch at active level for H cycles
//   EVT_INACTIVE | capch at idle level for L cycles
//   EVT_DONE     | one-cycle completion pulse
module tmr_evt_gen
    import tmr_evt_pkg::*;
#(
    parameter int PER_WIDTH = 20,
    parameter int NUM_WIDTH = 16,
    parameter int LAT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [2:0]           mode_i,
    input  logic [PER_WIDTH-1:0] high_i,
    input  logic [PER_WIDTH-1:0] low_i,
    input  logic [NUM_WIDTH-1:0] num_i,
    output logic                 capch_o,
    input  logic                 irq_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_WIDTH-1:0] evt_cnt_o,
    output logic [NUM_WIDTH-1:0] irq_cnt_o,
    output logic [LAT_WIDTH-1:0] lat_o,
    output logic                 lat_vld_o
);

    evt_state_e           state_q, state_d;
    logic [2:0]           mode_q;
    logic [PER_WIDTH-1:0] high_q, low_q, ph_cnt_q;
    logic [PER_WIDTH-1:0] high_cl, low_cl;
    logic [NUM_WIDTH-1:0] num_q, rem_q, evt_cnt_q, irq_cnt_q;
    logic [LAT_WIDTH-1:0] lat_cnt_q, lat_q;
    logic                 lat_vld_q;
    logic                 start_acc, ph_done, last_pulse, act_entry, irq_rise, idle_lvl;

    tmr_edge_det #(
        .EDGE_SEL (EDGE_RISE)
    ) u_irq_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sig_i   (irq_i),
        .edge_o  (irq_rise)
    );

    assign high_cl    = (high_i == '0) ? PER_WIDTH'(1) : high_i;
    assign low_cl     = (low_i == '0) ? PER_WIDTH'(1) : low_i;
    assign start_acc  = (state_q == EVT_IDLE) && start_i && !abort_i;
    assign ph_done    = (ph_cnt_q == '0);
    assign last_pulse = (num_q != '0) && (rem_q == NUM_WIDTH'(1));
    assign act_entry  = (start_acc && (mode_i != TMR_ETM_NONE)) ||
                        ((state_q == EVT_INACTIVE) && ph_done && !last_pulse && !abort_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EVT_IDLE: begin
                if (start_acc) begin
                    state_d = (mode_i == TMR_ETM_NONE) ? EVT_DONE : EVT_ACTIVE;
                end
            end
            EVT_ACTIVE: begin
                if (abort_i)      state_d = EVT_IDLE;
                else if (ph_done) state_d = EVT_INACTIVE;
            end
            EVT_INACTIVE: begin
                if (abort_i)      state_d = EVT_IDLE;
                else if (ph_done) state_d = last_pulse ? EVT_DONE : EVT_ACTIVE;
            end
            EVT_DONE: state_d = EVT_IDLE;
            default:  state_d = EVT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= EVT_IDLE;
            mode_q   <= TMR_ETM_NONE;
            high_q   <= '0;
            low_q    <= '0;
            num_q    <= '0;
            rem_q    <= '0;
            ph_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                mode_q   <= mode_i;
                high_q   <= high_cl;
                low_q    <= low_cl;
                num_q    <= num_i;
                rem_q    <= num_i;
                ph_cnt_q <= high_cl - PER_WIDTH'(1);
            end else if (state_q == EVT_ACTIVE) begin
                ph_cnt_q <= ph_done ? low_q - PER_WIDTH'(1) : ph_cnt_q - PER_WIDTH'(1);
            end else if (state_q == EVT_INACTIVE) begin
                if (ph_done) begin
                    ph_cnt_q <= high_q - PER_WIDTH'(1);
                    if (num_q != '0) rem_q <= rem_q - NUM_WIDTH'(1);
                end else begin
                    ph_cnt_q <= ph_cnt_q - PER_WIDTH'(1);
                end
            end
        end
    end

    // Counters are left untouched by abort so the host can read the partial run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_cnt_q <= '0;
            irq_cnt_q <= '0;
            lat_cnt_q <= '0;
            lat_q     <= '0;
            lat_vld_q <= 1'b0;
        end else begin
            if (start_acc)      evt_cnt_q <= act_entry ? NUM_WIDTH'(1) : '0;
            else if (act_entry) evt_cnt_q <= evt_cnt_q + NUM_WIDTH'(1);

            if (start_acc)     irq_cnt_q <= '0;
            else if (irq_rise) irq_cnt_q <= NUM_WIDTH'(sat_inc(64'(irq_cnt_q), NUM_WIDTH));

            if (start_acc || act_entry) lat_cnt_q <= '0;
            else lat_cnt_q <= LAT_WIDTH'(sat_inc(64'(lat_cnt_q), LAT_WIDTH));

            if (irq_rise) lat_q <= lat_cnt_q;
            lat_vld_q <= irq_rise;
        end
    end

    // mode_q resets to NONE, so reset forces capch low even mid-FALL train.
    assign idle_lvl  = (mode_q == TMR_ETM_FALL);
    assign capch_o   = (state_q == EVT_ACTIVE) ? ~idle_lvl : idle_lvl;
    assign busy_o    = (state_q != EVT_IDLE);
    assign done_o    = (state_q == EVT_DONE);
    assign evt_cnt_o = evt_cnt_q;
    assign irq_cnt_o = irq_cnt_q;
    assign lat_o     = lat_q;
    assign lat_vld_o = lat_vld_q;

endmodule

// File: tb/tb_tmr_evt_gen.sv
// Scoreboard bench for tmr_evt_gen: directed trains with hand-computed expectations.
module tb_tmr_evt_gen;
    import tmr_evt_pkg::*;

    localparam int PW = 20;
    localparam int NW = 8;
    localparam int LW = 32;

    logic          clk_sys;
    logic          rst_n_i;
    logic          start_i;
    logic          abort_i;
    logic [2:0]    mode_i;
    logic [PW-1:0] high_i;
    logic [PW-1:0] low_i;
    logic [NW-1:0] num_i;
    logic          capch_o;
    logic          irq_i;
    logic          busy_o;
    logic          done_o;
    logic [NW-1:0] evt_cnt_o;
    logic [NW-1:0] irq_cnt_o;
    logic [LW-1:0] lat_o;
    logic          lat_vld_o;

    typedef struct {
        longint lat;
        int     irq;
        int     evt;
    } lat_exp_t;

    typedef struct {
        int cyc;
        int evt;
    } done_exp_t;

    lat_exp_t  lat_q[$];
    done_exp_t done_q[$];
    int        cyc;
    int        n_chk;
    int        n_err;

    tmr_evt_gen #(
        .PER_WIDTH (PW),
        .NUM_WIDTH (NW),
        .LAT_WIDTH (LW)
    ) dut (
        .clk_i     (clk_sys),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .mode_i    (mode_i),
        .high_i    (high_i),
        .low_i     (low_i),
        .num_i     (num_i),
        .capch_o   (capch_o),
        .irq_i     (irq_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .evt_cnt_o (evt_cnt_o),
        .irq_cnt_o (irq_cnt_o),
        .lat_o     (lat_o),
        .lat_vld_o (lat_vld_o)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_start(input logic [2:0] m, input int h, input int l, input int n, output int t);
        mode_i  = m;
        high_i  = PW'(h);
        low_i   = PW'(l);
        num_i   = NW'(n);
        t       = cyc;
        start_i = 1'b1;
        goto(t + 1);
        start_i = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        if (rst_n_i) begin
            if (lat_vld_o) begin
                if (lat_q.size() == 0) begin
                    chk("lat_vld_spurious", 64'(lat_vld_o), 64'(0));
                end else begin
                    lat_exp_t e;
                    e = lat_q.pop_front();
                    chk("lat_value", 64'(lat_o), 64'(e.lat));
                    chk("lat_irq_cnt", 64'(irq_cnt_o), 64'(e.irq));
                    chk("lat_evt_cnt", 64'(evt_cnt_o), 64'(e.evt));
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("done_spurious", 64'(done_o), 64'(0));
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                    chk("done_evt_cnt", 64'(evt_cnt_o), 64'(d.evt));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        n_chk   = 0;
        n_err   = 0;
        rst_n_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        mode_i  = TMR_ETM_NONE;
        high_i  = '0;
        low_i   = '0;
        num_i   = '0;
        irq_i   = 1'b0;

        goto(3);
        chk("reset_outputs", 64'({capch_o, busy_o, done_o, lat_vld_o, evt_cnt_o, irq_cnt_o, lat_o}), 64'(0));
        rst_n_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            goto(cyc + 1);
            chk("idle_outputs", 64'({capch_o, busy_o, done_o, lat_vld_o, evt_cnt_o, irq_cnt_o, lat_o}), 64'(0));
        end

        // RISE, H=3 L=2 N=4
        do_start(TMR_ETM_RISE, 3, 2, 4, t);
        done_q.push_back('{t + 21, 4});
        for (int k = 1; k <= 21; k++) begin
            goto(t + k);
            chk("rise_capch", 64'(capch_o), 64'((k <= 20 && ((k - 1) % 5) < 3) ? 1 : 0));
        end
        chk("rise_busy_in_done", 64'(busy_o), 64'(1));
        goto(t + 22);
        chk("rise_busy_after", 64'(busy_o), 64'(0));
        chk("rise_evt_cnt", 64'(evt_cnt_o), 64'(4));

        // FALL, H=L=0 clamped to 1, N=2
        do_start(TMR_ETM_FALL, 0, 0, 2, t);
        done_q.push_back('{t + 5, 2});
        for (int k = 1; k <= 6; k++) begin
            goto(t + k);
            chk("fall_capch", 64'(capch_o), 64'((k > 4 || (k % 2) == 0) ? 1 : 0));
        end

        // CLER continuous, irq 7 cycles after each active entry, abort after 10 pulses
        do_start(TMR_ETM_CLER, 5, 5, 0, t);
        for (int c = 1; c <= 100; c++) begin
            goto(t + c);
            irq_i   = (c >= 8 && c < 100 && ((c - 8) % 10) < 2);
            abort_i = (c == 99);
            if (c >= 8 && c < 100 && ((c - 8) % 10) == 0)
                lat_q.push_back('{64'd7, (c - 8) / 10 + 1, (c - 8) / 10 + 1});
            if (c == 1) chk("cler_capch_active", 64'(capch_o), 64'(1));
            if (c == 6) chk("cler_capch_inactive", 64'(capch_o), 64'(0));
        end
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_capch", 64'(capch_o), 64'(0));
        chk("abort_evt_cnt", 64'(evt_cnt_o), 64'(10));
        chk("abort_irq_cnt", 64'(irq_cnt_o), 64'(10));
        chk("abort_lat_hold", 64'(lat_o), 64'(7));

        // start while busy, then abort+start in IDLE
        do_start(TMR_ETM_RISE, 2, 2, 3, t);
        done_q.push_back('{t + 13, 3});
        goto(t + 3);
        mode_i  = TMR_ETM_FALL;
        high_i  = PW'(7);
        num_i   = NW'(1);
        start_i = 1'b1;
        goto(t + 4);
        start_i = 1'b0;
        chk("busy_restart_capch_low", 64'(capch_o), 64'(0));
        goto(t + 5);
        chk("busy_restart_capch_high", 64'(capch_o), 64'(1));
        goto(t + 13);
        chk("busy_restart_done_capch", 64'(capch_o), 64'(0));
        goto(t + 14);
        chk("busy_restart_busy_after", 64'(busy_o), 64'(0));
        chk("busy_restart_evt_cnt", 64'(evt_cnt_o), 64'(3));
        goto(t + 15);
        start_i = 1'b1;
        abort_i = 1'b1;
        goto(t + 16);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_start_busy", 64'(busy_o), 64'(0));
        chk("abort_start_capch", 64'(capch_o), 64'(0));
        goto(t + 18);
        chk("abort_start_busy_later", 64'(busy_o), 64'(0));

        // NONE start, then irq saturation
        do_start(TMR_ETM_NONE, 3, 3, 2, t);
        done_q.push_back('{t + 1, 0});
        chk("none_busy", 64'(busy_o), 64'(1));
        chk("none_capch", 64'(capch_o), 64'(0));
        goto(t + 2);
        chk("none_busy_after", 64'(busy_o), 64'(0));
        chk("none_capch_after", 64'(capch_o), 64'(0));
        chk("none_evt_cnt", 64'(evt_cnt_o), 64'(0));
        for (int k = 1; k <= (1 << NW) + 3; k++) begin
            goto(t + 1 + 2 * k);
            irq_i = 1'b1;
            lat_q.push_back('{longint'(2 * k), (k < (1 << NW)) ? k : (1 << NW) - 1, 0});
            goto(t + 2 + 2 * k);
            irq_i = 1'b0;
        end
        goto(cyc + 3);
        chk("irq_cnt_saturated", 64'(irq_cnt_o), 64'((1 << NW) - 1));

        // async reset in the middle of a FALL train
        do_start(TMR_ETM_FALL, 4, 4, 0, t);
        goto(t + 6);
        chk("fall_train_capch_idle", 64'(capch_o), 64'(1));
        rst_n_i = 1'b0;
        #1;
        chk("reset_mid_capch", 64'(capch_o), 64'(0));
        chk("reset_mid_busy", 64'(busy_o), 64'(0));
        goto(cyc + 2);
        rst_n_i = 1'b1;
        goto(cyc + 2);
        chk("post_reset_capch", 64'(capch_o), 64'(0));
        chk("post_reset_evt_cnt", 64'(evt_cnt_o), 64'(0));

        chk("lat_q_drained", 64'(lat_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
